// File: rtl/mcs4_axi_loader.sv
// AXI4 burst master for the mcs4_sys slave port: turns load/dump commands into
// INCR write/read bursts that never exceed 256 beats or cross a 4 KB boundary.
module mcs4_axi_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_aresetn,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [9:0]                cmd_len,

    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,

    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_last,
    output logic                      rd_valid,
    input  logic                      rd_ready,

    output logic                      done,
    output logic                      err,

    output logic [3:0]                m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic [3:0]                m_axi_awregion,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    output logic [3:0]                m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic [3:0]                m_axi_arregion,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_W    = 3'd2;
    localparam logic [2:0] ST_B    = 3'd3;
    localparam logic [2:0] ST_AR   = 3'd4;
    localparam logic [2:0] ST_R    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [10:0]           remaining_q, remaining_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic [10:0]           words_to_boundary;
    logic [10:0]           beats_lim;
    logic [8:0]            beats;
    logic [7:0]            burst_len;
    logic                  final_burst;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^cmd_addr[1:0];

    // Burst size is derived from the live address/remaining registers, which
    // only change at a burst's completion, so awaddr/awlen stay stable in AW.
    assign words_to_boundary = 11'd1024 - {1'b0, addr_q[11:2]};
    assign beats_lim         = (remaining_q < words_to_boundary) ? remaining_q : words_to_boundary;
    assign beats             = (beats_lim > 11'd256) ? 9'd256 : beats_lim[8:0];
    assign burst_len         = 8'(beats - 9'd1);
    assign final_burst       = (remaining_q == {2'b00, beats});
    assign addr_next         = addr_q + ADDR_WIDTH'({beats, 2'b00});

    assign cmd_ready      = (state_q == ST_IDLE) & m_axi_aresetn;
    assign done           = done_q;
    assign err            = err_q;

    assign m_axi_awid     = '0;
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = burst_len;
    assign m_axi_awsize   = 3'b010;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = '0;
    assign m_axi_awprot   = '0;
    assign m_axi_awqos    = '0;
    assign m_axi_awregion = '0;
    assign m_axi_awvalid  = (state_q == ST_AW);

    assign m_axi_wdata    = wr_data;
    assign m_axi_wstrb    = '1;
    assign m_axi_wvalid   = (state_q == ST_W) & wr_valid;
    assign m_axi_wlast    = (state_q == ST_W) & (beat_cnt_q == (beats - 9'd1));
    assign wr_ready       = (state_q == ST_W) & m_axi_wready;

    assign m_axi_bready   = (state_q == ST_B);

    assign m_axi_arid     = '0;
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = burst_len;
    assign m_axi_arsize   = 3'b010;
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = '0;
    assign m_axi_arprot   = '0;
    assign m_axi_arqos    = '0;
    assign m_axi_arregion = '0;
    assign m_axi_arvalid  = (state_q == ST_AR);

    assign rd_data        = m_axi_rdata;
    assign rd_valid       = (state_q == ST_R) & m_axi_rvalid;
    assign rd_last        = (state_q == ST_R) & m_axi_rlast & final_burst;
    assign m_axi_rready   = (state_q == ST_R) & rd_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                    remaining_d = {1'b0, cmd_len} + 11'd1;
                    err_d       = 1'b0;
                    state_d     = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    beat_cnt_d = '0;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                if (wr_valid && m_axi_wready) begin
                    if (beat_cnt_q == (beats - 9'd1)) begin
                        state_d = ST_B;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 9'd1;
                    end
                end
            end
            ST_B: begin
                if (m_axi_bvalid) begin
                    err_d       = err_q | (m_axi_bresp != 2'b00);
                    addr_d      = addr_next;
                    remaining_d = remaining_q - {2'b00, beats};
                    if (final_burst) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_AW;
                    end
                end
            end
            ST_AR: begin
                if (m_axi_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                // Error status is collected on every read beat, not only the last.
                if (m_axi_rvalid && rd_ready) begin
                    err_d = err_q | (m_axi_rresp != 2'b00);
                    if (m_axi_rlast) begin
                        addr_d      = addr_next;
                        remaining_d = remaining_q - {2'b00, beats};
                        if (final_burst) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_AR;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_mcs4_axi_loader.sv
// Scoreboard bench for mcs4_axi_loader: directed commands push expected bursts,
// beats and completions; a monitor pops and compares on every DUT handshake.
module tb_mcs4_axi_loader;

    logic        clk;
    logic        m_axi_aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [13:0] cmd_addr;
    logic [9:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done, err;
    logic [3:0]  awid, awcache, awqos, awregion, arid, arcache, arqos, arregion;
    logic [13:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, arburst;
    logic        awlock, awvalid, awready, arlock, arvalid, arready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    mcs4_axi_loader #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(m_axi_aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err(err),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int testsRun;
    int testsFailed;
    int doneCount;
    int wSeen;
    int rBeat;
    int awStallLeft;
    int wrStallLeft;
    bit rdRandom;
    bit awPrevStalled;
    logic [21:0] awPrevBurst;

    logic [21:0] expAw[$];
    logic [21:0] expAr[$];
    logic [32:0] expW[$];
    logic [32:0] expRd[$];
    logic        expDone[$];
    logic [31:0] wrWords[$];
    logic [1:0]  brespCfg[$];
    logic [1:0]  bQueue[$];
    logic [21:0] rQueue[$];

    localparam logic [24:0] SIDEBAND_EXP = {3'b010, 2'b01, 20'h0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportExtra(input string name, input logic [63:0] actual);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: unexpected transfer 0x%0h, expected none", name, actual);
    endtask

    function automatic logic [21:0] burst(input logic [13:0] addr, input logic [7:0] len);
        return {addr, len};
    endfunction

    task automatic pushWord(input logic [31:0] data, input logic last);
        wrWords.push_back(data);
        expW.push_back({data, last});
    endtask

    // Slave and host drivers change inputs only on the falling edge.
    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        forever begin
            logic [13:0] rAddr;
            @(negedge clk);
            awready = (awStallLeft == 0);
            wready  = 1'b1;
            arready = 1'b1;
            bvalid  = (bQueue.size() > 0);
            bresp   = (bQueue.size() > 0) ? bQueue[0] : 2'b00;
            rresp   = 2'b00;
            if (rQueue.size() > 0) begin
                rAddr  = rQueue[0][21:8] + 14'(rBeat * 4);
                rvalid = 1'b1;
                rdata  = {16'hC0DE, 2'b00, rAddr};
                rlast  = (rBeat == int'(rQueue[0][7:0]));
            end else begin
                rvalid = 1'b0;
                rdata  = '0;
                rlast  = 1'b0;
            end
            wr_valid = (wrWords.size() > 0) && (wrStallLeft == 0);
            wr_data  = (wrWords.size() > 0) ? wrWords[0] : 32'h0;
            rd_ready = rdRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Slave/host model state follows the handshakes due at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (m_axi_aresetn) begin
                if (wrStallLeft > 0 && wr_ready) wrStallLeft--;
                if (wr_valid && wr_ready) void'(wrWords.pop_front());
                if (awvalid && !awready && awStallLeft > 0) awStallLeft--;
                if (wvalid && wready && wlast)
                    bQueue.push_back((brespCfg.size() > 0) ? brespCfg.pop_front() : 2'b00);
                if (bvalid && bready) void'(bQueue.pop_front());
                if (arvalid && arready) rQueue.push_back({araddr, arlen});
                if (rvalid && rready) begin
                    if (rlast) begin
                        void'(rQueue.pop_front());
                        rBeat = 0;
                    end else begin
                        rBeat++;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!m_axi_aresetn) begin
                awPrevStalled = 1'b0;
            end else begin
                if (awPrevStalled) begin
                    checkOutput("aw_hold_valid", 64'(awvalid), 64'd1);
                    checkOutput("aw_hold_burst", 64'({awaddr, awlen}), 64'(awPrevBurst));
                end
                awPrevStalled = awvalid && !awready;
                awPrevBurst   = {awaddr, awlen};
                if (awvalid && awready) begin
                    checkOutput("aw_sideband", 64'({awsize, awburst, awid, awlock, awcache, awprot, awqos, awregion}),
                                64'(SIDEBAND_EXP));
                    if (expAw.size() == 0) reportExtra("aw_burst", 64'({awaddr, awlen}));
                    else checkOutput("aw_burst", 64'({awaddr, awlen}), 64'(expAw.pop_front()));
                end
                if (wvalid && wready) begin
                    wSeen++;
                    checkOutput("w_strb", 64'(wstrb), 64'hF);
                    if (expW.size() == 0) reportExtra("w_beat", 64'({wdata, wlast}));
                    else checkOutput("w_beat", 64'({wdata, wlast}), 64'(expW.pop_front()));
                end
                if (arvalid && arready) begin
                    checkOutput("ar_sideband", 64'({arsize, arburst, arid, arlock, arcache, arprot, arqos, arregion}),
                                64'(SIDEBAND_EXP));
                    if (expAr.size() == 0) reportExtra("ar_burst", 64'({araddr, arlen}));
                    else checkOutput("ar_burst", 64'({araddr, arlen}), 64'(expAr.pop_front()));
                end
                if (rd_valid && rd_ready) begin
                    if (expRd.size() == 0) reportExtra("rd_beat", 64'({rd_data, rd_last}));
                    else checkOutput("rd_beat", 64'({rd_data, rd_last}), 64'(expRd.pop_front()));
                end
                if (done) begin
                    doneCount++;
                    if (expDone.size() == 0) reportExtra("done_pulse", 64'(err));
                    else checkOutput("err_at_done", 64'(err), 64'(expDone.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [13:0] addr, input logic [9:0] len);
        bit accepted;
        accepted = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("cmd_accept", 64'(accepted), 64'd1);
        #1;
        checkOutput("err_clear_on_accept", 64'(err), 64'd0);
    endtask

    task automatic waitDone(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (doneCount >= target) break;
        end
        checkOutput("done_seen", 64'(doneCount), 64'(target));
        repeat (3) @(negedge clk);
        #2;
        checkOutput("done_single", 64'(doneCount), 64'(target));
        checkOutput("aw_drained", 64'(expAw.size()), 64'd0);
        checkOutput("w_drained", 64'(expW.size()), 64'd0);
        checkOutput("ar_drained", 64'(expAr.size()), 64'd0);
        checkOutput("rd_drained", 64'(expRd.size()), 64'd0);
    endtask

    task automatic flushModel();
        expAw.delete(); expAr.delete(); expW.delete(); expRd.delete(); expDone.delete();
        wrWords.delete(); brespCfg.delete(); bQueue.delete(); rQueue.delete();
        rBeat = 0; awStallLeft = 0; wrStallLeft = 0;
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput(name, 64'({cmd_ready, awvalid, wvalid, wlast, wr_ready, bready, arvalid,
                               rready, rd_valid, rd_last, done, err}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        testsRun = 0; testsFailed = 0; doneCount = 0; wSeen = 0; rBeat = 0;
        awStallLeft = 0; wrStallLeft = 0; rdRandom = 1'b0; awPrevStalled = 1'b0;
        awPrevBurst = '0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        m_axi_aresetn = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("reset_outputs");
        checkOutput("reset_addr", 64'(awaddr), 64'd0);
        @(negedge clk);
        m_axi_aresetn = 1'b1;
        #1;
        checkOutput("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Single-word write.
        expAw.push_back(burst(14'h0010, 8'd0));
        pushWord(32'hDEADBEEF, 1'b1);
        expDone.push_back(1'b0);
        applyStimulus(1'b1, 14'h0010, 10'd0);
        waitDone(1, 100);

        // Write split at the 4 KB boundary.
        expAw.push_back(burst(14'h0FF8, 8'd1));
        expAw.push_back(burst(14'h1000, 8'd1));
        pushWord(32'h11111111, 1'b0);
        pushWord(32'h22222222, 1'b1);
        pushWord(32'h33333333, 1'b0);
        pushWord(32'h44444444, 1'b1);
        expDone.push_back(1'b0);
        applyStimulus(1'b1, 14'h0FF8, 10'd3);
        waitDone(2, 100);

        // 300-word read split into 256 + 44 with random rd_ready.
        expAr.push_back(burst(14'h2000, 8'd255));
        expAr.push_back(burst(14'h2400, 8'd43));
        for (int i = 0; i < 300; i++) begin
            logic [13:0] a;
            a = 14'h2000 + 14'(4 * i);
            expRd.push_back({16'hC0DE, 2'b00, a, (i == 299)});
        end
        expDone.push_back(1'b0);
        rdRandom = 1'b1;
        applyStimulus(1'b0, 14'h2000, 10'd299);
        waitDone(3, 3000);
        rdRandom = 1'b0;

        // SLVERR on the first of two bursts; the second still runs.
        brespCfg.push_back(2'b10);
        brespCfg.push_back(2'b00);
        expAw.push_back(burst(14'h0FF8, 8'd1));
        expAw.push_back(burst(14'h1000, 8'd1));
        pushWord(32'h55555555, 1'b0);
        pushWord(32'h66666666, 1'b1);
        pushWord(32'h77777777, 1'b0);
        pushWord(32'h88888888, 1'b1);
        expDone.push_back(1'b1);
        applyStimulus(1'b1, 14'h0FF8, 10'd3);
        waitDone(4, 100);
        checkOutput("err_sticky", 64'(err), 64'd1);

        // Stalled AW and write stream at the top of the address space.
        awStallLeft = 5;
        wrStallLeft = 5;
        expAw.push_back(burst(14'h3FFC, 8'd0));
        expAw.push_back(burst(14'h0000, 8'd0));
        pushWord(32'h12345678, 1'b1);
        pushWord(32'h9ABCDEF0, 1'b1);
        expDone.push_back(1'b0);
        applyStimulus(1'b1, 14'h3FFC, 10'd1);
        waitDone(5, 200);

        // Reset after two of eight write beats.
        base = wSeen;
        expAw.push_back(burst(14'h0100, 8'd7));
        pushWord(32'hF0000000, 1'b0);
        pushWord(32'hF0000001, 1'b0);
        for (int i = 2; i < 8; i++) wrWords.push_back(32'hF0000000 + 32'(i));
        applyStimulus(1'b1, 14'h0100, 10'd7);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (wSeen >= base + 2) break;
        end
        checkOutput("w_before_reset", 64'(wSeen - base), 64'd2);
        @(negedge clk);
        m_axi_aresetn = 1'b0;
        flushModel();
        #1;
        checkResetOutputs("mid_burst_reset_outputs");
        checkOutput("mid_burst_reset_wvalid", 64'(wvalid), 64'd0);
        repeat (3) @(negedge clk);
        m_axi_aresetn = 1'b1;
        #1;
        checkOutput("cmd_ready_after_release", 64'(cmd_ready), 64'd1);
        checkOutput("no_beats_after_reset", 64'(wSeen - base), 64'd2);

        expAw.push_back(burst(14'h0200, 8'd1));
        pushWord(32'hA0A0A0A0, 1'b0);
        pushWord(32'h0B0B0B0B, 1'b1);
        expDone.push_back(1'b0);
        applyStimulus(1'b1, 14'h0200, 10'd1);
        waitDone(6, 100);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
